// File: rtl/mem_access_ctrl_if.sv
// Request/response and main_memory signal bundle for mem_access_ctrl.
// The slave modport is the controller side; master is the requester/memory side.
interface mem_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_data_out;

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata,
    input  resp_ready, mem_data_out,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_address, mem_data_in, mem_rd, mem_wr
  );

  modport master (
    output req_valid, req_wr, req_addr, req_wdata,
    output resp_ready, mem_data_out,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_address, mem_data_in, mem_rd, mem_wr
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store front-end for main_memory.
// Issues one rd/wr strobe per request and waits out the read latency.
module mem_access_ctrl #(
  parameter int READ_LATENCY = 1,
  parameter int ALIGN_CHECK  = 1
) (
  input logic              clk,
  input logic              rst,
  mem_access_ctrl_if.slave bus
);
  localparam int CW = $clog2(READ_LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          rd_stb_q, rd_stb_d;
  logic          wr_stb_q, wr_stb_d;
  logic          rvalid_q, rvalid_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          rerr_q, rerr_d;
  logic          misaligned;

  assign misaligned = (ALIGN_CHECK != 0) &&
                      (bus.req_addr[1:0] != 2'b00);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rd_stb_d = 1'b0;
    wr_stb_d = 1'b0;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rerr_d   = rerr_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          wr_d    = bus.req_wr;
          if (misaligned) begin
            state_d  = RESP;
            rvalid_d = 1'b1;
            rerr_d   = 1'b1;
            rdata_d  = 32'h0;
          end else begin
            // strobes are registered, so raise them here to be live in ISSUE
            state_d  = ISSUE;
            wr_stb_d = bus.req_wr;
            rd_stb_d = !bus.req_wr;
          end
        end
      end
      ISSUE: begin
        if (wr_q) begin
          state_d  = RESP;
          rvalid_d = 1'b1;
          rdata_d  = 32'h0;
        end else begin
          state_d = WAIT;
          cnt_d   = CW'(READ_LATENCY);
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d  = RESP;
          rvalid_d = 1'b1;
          rdata_d  = bus.mem_data_out;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d  = IDLE;
          rvalid_d = 1'b0;
          rerr_d   = 1'b0;
          rdata_d  = 32'h0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      rd_stb_q <= 1'b0;
      wr_stb_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'h0;
      rerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rd_stb_q <= rd_stb_d;
      wr_stb_q <= wr_stb_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rerr_q   <= rerr_d;
    end
  end

  assign bus.req_ready   = (state_q == IDLE);
  assign bus.resp_valid  = rvalid_q;
  assign bus.resp_rdata  = rdata_q;
  assign bus.resp_err    = rerr_q;
  assign bus.mem_address = addr_q;
  assign bus.mem_data_in = wdata_q;
  assign bus.mem_rd      = rd_stb_q;
  assign bus.mem_wr      = wr_stb_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed + randomized bench for mem_access_ctrl against a
// transaction-level reference (address->data map, fixed latencies).
module tb_mem_access_ctrl;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  mem_access_ctrl_if bus1 ();
  mem_access_ctrl_if bus3 ();

  mem_access_ctrl #(.READ_LATENCY(1), .ALIGN_CHECK(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  mem_access_ctrl #(.READ_LATENCY(3), .ALIGN_CHECK(1)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // main_memory stand-ins: storage plus registered read delay line
  logic [31:0] mem1 [logic [31:0]];
  logic [31:0] mem3 [logic [31:0]];
  logic [31:0] p1;
  logic [31:0] p3_0, p3_1, p3_2;

  function automatic logic [31:0] rd1(input logic [31:0] a);
    return mem1.exists(a) ? mem1[a] : 32'h0;
  endfunction

  function automatic logic [31:0] rd3(input logic [31:0] a);
    return mem3.exists(a) ? mem3[a] : 32'h0;
  endfunction

  always @(posedge clk) begin
    if (bus1.mem_wr) mem1[bus1.mem_address] = bus1.mem_data_in;
    if (bus1.mem_rd) p1 <= rd1(bus1.mem_address);
    if (bus3.mem_rd) p3_0 <= rd3(bus3.mem_address);
    p3_1 <= p3_0;
    p3_2 <= p3_1;
  end

  assign bus1.mem_data_out = p1;
  assign bus3.mem_data_out = p3_2;

  int n_rd, n_wr, n_both;
  always @(posedge clk) begin
    if (bus1.mem_rd === 1'b1) n_rd++;
    if (bus1.mem_wr === 1'b1) n_wr++;
    if (bus1.mem_rd === 1'b1 && bus1.mem_wr === 1'b1) n_both++;
  end

  // reference: what a load should return
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_txn(input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int hold);
    logic        mis;
    logic [31:0] exp_rd;
    int          lat, exp_lat, rd0, wr0;
    mis     = (addr[1:0] != 2'b00);
    exp_rd  = (wr || mis) ? 32'h0 : ref_rd(addr);
    exp_lat = mis ? 1 : (wr ? 2 : 3);
    chk("req_ready_idle", 32'(bus1.req_ready), 32'd1);
    rd0 = n_rd;
    wr0 = n_wr;
    bus1.req_valid = 1'b1;
    bus1.req_wr    = wr;
    bus1.req_addr  = addr;
    bus1.req_wdata = wdata;
    @(posedge clk); #1;
    bus1.req_valid = 1'b0;
    bus1.req_addr  = $urandom;
    bus1.req_wdata = $urandom;
    lat = 1;
    while (bus1.resp_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("rdata", bus1.resp_rdata, exp_rd);
    chk("err", 32'(bus1.resp_err), 32'(mis));
    if (!mis) chk("mem_address", bus1.mem_address, addr);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(bus1.resp_valid), 32'd1);
      chk("hold_rdata", bus1.resp_rdata, exp_rd);
      chk("hold_ready", 32'(bus1.req_ready), 32'd0);
      if (!mis) chk("hold_addr", bus1.mem_address, addr);
    end
    bus1.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus1.resp_ready = 1'b0;
    chk("post_valid", 32'(bus1.resp_valid), 32'd0);
    chk("post_rdata", bus1.resp_rdata, 32'h0);
    chk("post_err", 32'(bus1.resp_err), 32'd0);
    chk("post_ready", 32'(bus1.req_ready), 32'd1);
    chk("rd_pulses", 32'(n_rd - rd0), 32'(!wr && !mis));
    chk("wr_pulses", 32'(n_wr - wr0), 32'(wr && !mis));
    if (wr && !mis) ref_mem[addr] = wdata;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "time limit");
  end

  initial begin
    logic        wr;
    logic [31:0] a;
    int          lat;
    checks   = 0;
    failures = 0;
    mem1[32'h0]    = 32'hC200_2001;
    ref_mem[32'h0] = 32'hC200_2001;
    mem3[32'h0]    = 32'hC200_2001;
    mem3[32'h40]   = 32'h1234_5678;
    p1 = 0; p3_0 = 0; p3_1 = 0; p3_2 = 0;
    bus1.req_valid = 0; bus1.req_wr = 0; bus1.req_addr = 0;
    bus1.req_wdata = 0; bus1.resp_ready = 0;
    bus3.req_valid = 0; bus3.req_wr = 0; bus3.req_addr = 0;
    bus3.req_wdata = 0; bus3.resp_ready = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_req_ready", 32'(bus1.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus1.resp_valid), 32'd0);
    chk("rst_mem_rd", 32'(bus1.mem_rd), 32'd0);
    chk("rst_mem_wr", 32'(bus1.mem_wr), 32'd0);
    chk("rst_rdata", bus1.resp_rdata, 32'h0);
    chk("rst_mem_addr", bus1.mem_address, 32'h0);

    do_txn(1'b1, 32'd2048, 32'hDEAD_BEEF, 0);
    do_txn(1'b0, 32'd2048, 32'h0, 0);
    do_txn(1'b0, 32'd2049, 32'h0, 0);
    do_txn(1'b0, 32'd2048, 32'h0, 5);

    // reset lands while the load of 0 sits in WAIT
    bus1.req_valid = 1'b1;
    bus1.req_wr    = 1'b0;
    bus1.req_addr  = 32'h0;
    @(posedge clk); #1;
    bus1.req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("abort_no_valid", 32'(bus1.resp_valid), 32'd0);
      @(posedge clk); #1;
    end
    do_txn(1'b0, 32'h0, 32'h0, 1);

    bus3.req_valid = 1'b1;
    bus3.req_wr    = 1'b0;
    bus3.req_addr  = 32'h40;
    @(posedge clk); #1;
    bus3.req_valid = 1'b0;
    lat = 1;
    while (bus3.resp_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("rl3_latency", 32'(lat), 32'd5);
    chk("rl3_rdata", bus3.resp_rdata, 32'h1234_5678);
    bus3.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus3.resp_ready = 1'b0;
    chk("rl3_post_ready", 32'(bus3.req_ready), 32'd1);

    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom);
      a  = {24'h0, 6'($urandom_range(1, 63)), 2'b00};
      if ($urandom_range(0, 4) == 0) a[1:0] = 2'($urandom_range(1, 3));
      do_txn(wr, a, $urandom, $urandom_range(0, 2));
    end
    chk("never_both_strobes", 32'(n_both), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
